arf_sequencer: RTL and testbench
================================

ARF_SEQUENCER -- requirements
Module: arf_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 op_valid  in  1  requester has an operation pending.
REQ-004 op_ready  out  1  sequencer can accept an operation.
REQ-005 op_code  in  3  000 FETCH, 001 JUMP, 010 PUSH, 011 POP, 100 CALL, 101 RET, 110 CLEAR, 111 illegal.
REQ-006 op_data  in  8  jump/call target.
REQ-007 arf_funsel  out  2  to ARF: 00 clear, 01 load, 10 decrement, 11 increment.
REQ-008 arf_rsel  out  4  to ARF write enables: bit3 AR, bit2 SP, bit1 PCPrev, bit0 PC.
REQ-009 arf_i  out  8  to ARF load data.
REQ-010 arf_out_a_sel, arf_out_b_sel  out  2 each  to ARF read selects: 00 AR, 01 SP, 10 PCPrev, 11 PC.
REQ-011 arf_out_a, arf_out_b  in  8 each  ARF read data (combinational).
REQ-012 mem_addr  out  8  memory address; mem_wr, mem_rd  out  1 each  memory strobes.
REQ-013 mem_wdata  out  8  store data; mem_rdata  in  8  load data, valid one cycle after mem_rd.
REQ-014 done  out  1  one-cycle pulse on final step; err  out  1  one-cycle pulse for illegal op.

Function
REQ-015 op_ready SHALL be 1 exactly when FSM is IDLE; transfer occurs on edge with op_valid && op_ready; op_code/op_data SHALL be latched then.
REQ-016 FSM states SHALL be IDLE, STEP1, STEP2, STEP3; accepted op enters STEP1, advances one step per cycle, returns to IDLE after its last step.
REQ-017 In IDLE and any unused step: arf_rsel=0000, arf_funsel=01, mem_wr=mem_rd=0, done=err=0.
REQ-018 FETCH (2 steps): S1 out_a_sel=PC, mem_addr=arf_out_a, mem_rd=1, load PCPrev with arf_out_a; S2 increment PC, done=1.
REQ-019 JUMP (1 step): load PC with latched op_data, done=1.
REQ-020 PUSH (2 steps): S1 decrement SP; S2 out_a_sel=SP, mem_addr=arf_out_a, mem_wr=1, mem_wdata=latched op_data, done=1.
REQ-021 POP (2 steps): S1 mem_addr=SP, mem_rd=1; S2 increment SP, done=1.
REQ-022 CALL (3 steps): S1 decrement SP; S2 mem_addr=SP, out_b_sel=PC, mem_wdata=arf_out_b, mem_wr=1; S3 load PC with op_data, done=1.
REQ-023 RET (3 steps): S1 mem_addr=SP, mem_rd=1; S2 latch mem_rdata, increment SP; S3 load PC with latched value, done=1.
REQ-024 CLEAR (1 step): funsel=00, rsel=1111, done=1.
REQ-025 Illegal 111 (1 step): no ARF write or memory strobe, err=1, done=1.
REQ-026 Exactly one funsel/rsel command per cycle; no two registers written with differing functions in one cycle.
REQ-027 SP/PC wrap-around (00 dec -> FF, FF inc -> 00) SHALL be left to the ARF; sequencer issues identical commands at boundaries.
REQ-028 op_valid toggling while busy SHALL be ignored; back-to-back ops: next accept on cycle after done.

Reset
REQ-029 rst_n low SHALL force IDLE immediately: op_ready=1, rsel=0000, funsel=01, arf_i=00, mem_addr=00, mem_wdata=00, mem_wr=mem_rd=0, done=err=0, latches cleared.
REQ-030 Reset mid-operation SHALL abort the op: no further ARF write, strobe or done for it.
REQ-031 Sequencer SHALL NOT clear the ARF on reset; CLEAR op is the only clear path.

Structure
REQ-032 Package arf_seq_pkg SHALL hold opcode enum, funsel codes, rsel one-hot masks, out_sel codes, state enum.
REQ-033 Single FSM module; no sub-module is natural; bench instantiates arf_sequencer with the real ARF.

Verification
REQ-034 Reset, CLEAR -> all four ARF regs 00, done at cycle 2 after accept, op_ready high cycle 3.
REQ-035 JUMP 0x3C then FETCH -> mem_addr=3C with mem_rd in S1, PCPrev=3C, PC=3D, done pulses once.
REQ-036 SP=00, PUSH 0xA5 -> SP=FF, mem_addr=FF, mem_wdata=A5, mem_wr one cycle; POP -> mem_addr=FF, SP=00.
REQ-037 PC=10, SP=80, CALL 0x40 -> write 10 to 7F, SP=7F, PC=40; RET with mem_rdata=10 -> SP=80, PC=10.
REQ-038 op_code 111 -> err and done pulse, ARF unchanged; rst_n low during CALL S2 -> PC unchanged, no done.

Source files
------------

// File: rtl/arf_seq_pkg.sv
// Shared types for the ARF sequencer: opcodes, ARF command codes, FSM states
// and the per-step command word that the FSM registers onto its outputs.
package arf_seq_pkg;

  typedef enum logic [2:0] {
    OP_FETCH   = 3'b000,
    OP_JUMP    = 3'b001,
    OP_PUSH    = 3'b010,
    OP_POP     = 3'b011,
    OP_CALL    = 3'b100,
    OP_RET     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_ILLEGAL = 3'b111
  } op_e;

  typedef enum logic [1:0] {IDLE, STEP1, STEP2, STEP3} state_e;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_DEC  = 2'b10;
  localparam logic [1:0] FUN_INC  = 2'b11;

  localparam logic [3:0] RSEL_NONE = 4'b0000;
  localparam logic [3:0] RSEL_AR   = 4'b1000;
  localparam logic [3:0] RSEL_SP   = 4'b0100;
  localparam logic [3:0] RSEL_PCP  = 4'b0010;
  localparam logic [3:0] RSEL_PC   = 4'b0001;
  localparam logic [3:0] RSEL_ALL  = RSEL_AR | RSEL_SP | RSEL_PCP | RSEL_PC;

  localparam logic [1:0] SEL_AR  = 2'b00;
  localparam logic [1:0] SEL_SP  = 2'b01;
  localparam logic [1:0] SEL_PCP = 2'b10;
  localparam logic [1:0] SEL_PC  = 2'b11;

  // Where arf_i and mem_wdata take their value from during a step
  typedef enum logic [1:0] {ISRC_ZERO, ISRC_OUT_A, ISRC_DATA, ISRC_RET} isrc_e;
  typedef enum logic [1:0] {WSRC_ZERO, WSRC_DATA, WSRC_OUT_B} wsrc_e;

  typedef struct packed {
    logic [1:0] funsel;
    logic [3:0] rsel;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_a;
    isrc_e      isrc;
    wsrc_e      wsrc;
    logic       done;
    logic       err;
  } cmd_t;

  localparam cmd_t CMD_IDLE = '{funsel: FUN_LOAD, rsel: RSEL_NONE, a_sel: SEL_AR,
                                b_sel: SEL_AR, mem_rd: 1'b0, mem_wr: 1'b0,
                                addr_a: 1'b0, isrc: ISRC_ZERO, wsrc: WSRC_ZERO,
                                done: 1'b0, err: 1'b0};

  function automatic state_e last_step(input op_e op);
    case (op)
      OP_FETCH, OP_PUSH, OP_POP: return STEP2;
      OP_CALL, OP_RET:           return STEP3;
      default:                   return STEP1;
    endcase
  endfunction

  function automatic cmd_t step_cmd(input op_e op, input state_e st);
    cmd_t c;
    c = CMD_IDLE;
    case (op)
      OP_FETCH:
        if (st == STEP1) begin
          c.a_sel = SEL_PC; c.addr_a = 1'b1; c.mem_rd = 1'b1;
          c.rsel = RSEL_PCP; c.isrc = ISRC_OUT_A;
        end else if (st == STEP2) begin
          c.rsel = RSEL_PC; c.funsel = FUN_INC; c.done = 1'b1;
        end
      OP_JUMP:
        if (st == STEP1) begin
          c.rsel = RSEL_PC; c.isrc = ISRC_DATA; c.done = 1'b1;
        end
      OP_PUSH:
        if (st == STEP1) begin
          c.rsel = RSEL_SP; c.funsel = FUN_DEC;
        end else if (st == STEP2) begin
          c.a_sel = SEL_SP; c.addr_a = 1'b1; c.mem_wr = 1'b1;
          c.wsrc = WSRC_DATA; c.done = 1'b1;
        end
      OP_POP:
        if (st == STEP1) begin
          c.a_sel = SEL_SP; c.addr_a = 1'b1; c.mem_rd = 1'b1;
        end else if (st == STEP2) begin
          c.rsel = RSEL_SP; c.funsel = FUN_INC; c.done = 1'b1;
        end
      OP_CALL:
        if (st == STEP1) begin
          c.rsel = RSEL_SP; c.funsel = FUN_DEC;
        end else if (st == STEP2) begin
          c.a_sel = SEL_SP; c.addr_a = 1'b1; c.b_sel = SEL_PC;
          c.wsrc = WSRC_OUT_B; c.mem_wr = 1'b1;
        end else if (st == STEP3) begin
          c.rsel = RSEL_PC; c.isrc = ISRC_DATA; c.done = 1'b1;
        end
      OP_RET:
        if (st == STEP1) begin
          c.a_sel = SEL_SP; c.addr_a = 1'b1; c.mem_rd = 1'b1;
        end else if (st == STEP2) begin
          c.rsel = RSEL_SP; c.funsel = FUN_INC;
        end else if (st == STEP3) begin
          c.rsel = RSEL_PC; c.isrc = ISRC_RET; c.done = 1'b1;
        end
      OP_CLEAR:
        if (st == STEP1) begin
          c.rsel = RSEL_ALL; c.funsel = FUN_CLR; c.done = 1'b1;
        end
      default:
        if (st == STEP1) begin
          c.err = 1'b1; c.done = 1'b1;
        end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arf_sequencer_if.sv
// Operation handshake, completion pulses and memory bus of the ARF sequencer.
interface arf_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_data;
  logic [7:0] mem_addr;
  logic       mem_wr;
  logic       mem_rd;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       done;
  logic       err;

  modport master (
    output op_valid, op_code, op_data, mem_rdata,
    input  op_ready, mem_addr, mem_wr, mem_rd, mem_wdata, done, err
  );

  modport slave (
    input  op_valid, op_code, op_data, mem_rdata,
    output op_ready, mem_addr, mem_wr, mem_rd, mem_wdata, done, err
  );
endinterface

// File: rtl/arf_sequencer.sv
// Multi-step sequencer driving an address register file and memory strobes.
// Step commands are registered; only ARF read data is muxed combinationally.
module arf_sequencer
  import arf_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  arf_sequencer_if.slave  bus,
  output logic [1:0]      arf_funsel,
  output logic [3:0]      arf_rsel,
  output logic [7:0]      arf_i,
  output logic [1:0]      arf_out_a_sel,
  output logic [1:0]      arf_out_b_sel,
  input  logic [7:0]      arf_out_a,
  input  logic [7:0]      arf_out_b
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] ret_q, ret_d;
  cmd_t       cmd_q, cmd_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    ret_d   = ret_q;
    cmd_d   = cmd_q;
    if (state_q == IDLE) begin
      if (bus.op_valid) begin
        op_d    = op_e'(bus.op_code);
        data_d  = bus.op_data;
        state_d = STEP1;
        cmd_d   = step_cmd(op_e'(bus.op_code), STEP1);
      end
    end else if (state_q == last_step(op_q)) begin
      state_d = IDLE;
      cmd_d   = CMD_IDLE;
    end else begin
      if (state_q == STEP1) state_d = STEP2;
      else                  state_d = STEP3;
      cmd_d = step_cmd(op_q, state_d);
    end
    // Return address arrives the cycle after the RET read strobe
    if (state_q == STEP2 && op_q == OP_RET) ret_d = bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_FETCH;
      data_q  <= 8'h00;
      ret_q   <= 8'h00;
      cmd_q   <= CMD_IDLE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      ret_q   <= ret_d;
      cmd_q   <= cmd_d;
    end
  end

  assign bus.op_ready  = (state_q == IDLE);
  assign bus.mem_rd    = cmd_q.mem_rd;
  assign bus.mem_wr    = cmd_q.mem_wr;
  assign bus.done      = cmd_q.done;
  assign bus.err       = cmd_q.err;
  assign bus.mem_addr  = cmd_q.addr_a ? arf_out_a : 8'h00;
  assign arf_funsel    = cmd_q.funsel;
  assign arf_rsel      = cmd_q.rsel;
  assign arf_out_a_sel = cmd_q.a_sel;
  assign arf_out_b_sel = cmd_q.b_sel;

  always_comb begin
    case (cmd_q.isrc)
      ISRC_OUT_A: arf_i = arf_out_a;
      ISRC_DATA:  arf_i = data_q;
      ISRC_RET:   arf_i = ret_q;
      default:    arf_i = 8'h00;
    endcase
  end

  always_comb begin
    case (cmd_q.wsrc)
      WSRC_DATA:  bus.mem_wdata = data_q;
      WSRC_OUT_B: bus.mem_wdata = arf_out_b;
      default:    bus.mem_wdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: bench-side ARF and memory, an operation-level
// reference model producing per-cycle bus expectations, directed and random stimulus.
module tb_arf_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arf_sequencer_if bus();
  logic [1:0] arf_funsel, a_sel, b_sel;
  logic [3:0] arf_rsel;
  logic [7:0] arf_i, out_a, out_b;

  arf_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .arf_funsel(arf_funsel), .arf_rsel(arf_rsel), .arf_i(arf_i),
    .arf_out_a_sel(a_sel), .arf_out_b_sel(b_sel),
    .arf_out_a(out_a), .arf_out_b(out_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Bench-side ARF: not reset, combinational reads
  logic [7:0] ar = 8'h11, sp = 8'h22, pcp = 8'h33, pc = 8'h44;

  function automatic logic [7:0] arf_fn(input logic [7:0] v, input logic [1:0] f, input logic [7:0] d);
    case (f)
      2'b00:   return 8'h00;
      2'b01:   return d;
      2'b10:   return v - 8'd1;
      default: return v + 8'd1;
    endcase
  endfunction

  function automatic logic [7:0] arf_rd(input logic [1:0] s, input logic [7:0] r0, r1, r2, r3);
    case (s)
      2'b00:   return r0;
      2'b01:   return r1;
      2'b10:   return r2;
      default: return r3;
    endcase
  endfunction

  assign out_a = arf_rd(a_sel, ar, sp, pcp, pc);
  assign out_b = arf_rd(b_sel, ar, sp, pcp, pc);

  always @(posedge clk) begin
    if (arf_rsel[3]) ar  <= arf_fn(ar,  arf_funsel, arf_i);
    if (arf_rsel[2]) sp  <= arf_fn(sp,  arf_funsel, arf_i);
    if (arf_rsel[1]) pcp <= arf_fn(pcp, arf_funsel, arf_i);
    if (arf_rsel[0]) pc  <= arf_fn(pc,  arf_funsel, arf_i);
  end

  // Bench memory: synchronous read, data valid the cycle after mem_rd
  logic [7:0] mem [256];
  logic       mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      mem_init <= 1'b1;
    end else begin
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // Reference model: each accepted op expands into one record per cycle
  typedef struct packed {
    logic       rd, wr, done, err;
    logic [7:0] addr, wdata;
    logic       set_pcp, set_pc, set_sp, clr;
    logic [7:0] pcp_v, pc_v, sp_v;
  } rec_t;

  rec_t       exp_q [$];
  logic [7:0] m_ar = 8'h11, m_sp = 8'h22, m_pcp = 8'h33, m_pc = 8'h44;
  logic [7:0] m_mem [256];

  task automatic gen(input logic [2:0] op, input logic [7:0] d);
    rec_t r1, r2, r3;
    r1 = '0; r2 = '0; r3 = '0;
    case (op)
      3'd0: begin
        r1.rd = 1; r1.addr = m_pc; r1.set_pcp = 1; r1.pcp_v = m_pc;
        r2.done = 1; r2.set_pc = 1; r2.pc_v = m_pc + 8'd1;
        exp_q.push_back(r1); exp_q.push_back(r2);
      end
      3'd1: begin
        r1.done = 1; r1.set_pc = 1; r1.pc_v = d;
        exp_q.push_back(r1);
      end
      3'd2: begin
        r1.set_sp = 1; r1.sp_v = m_sp - 8'd1;
        r2.wr = 1; r2.addr = m_sp - 8'd1; r2.wdata = d; r2.done = 1;
        exp_q.push_back(r1); exp_q.push_back(r2);
      end
      3'd3: begin
        r1.rd = 1; r1.addr = m_sp;
        r2.set_sp = 1; r2.sp_v = m_sp + 8'd1; r2.done = 1;
        exp_q.push_back(r1); exp_q.push_back(r2);
      end
      3'd4: begin
        r1.set_sp = 1; r1.sp_v = m_sp - 8'd1;
        r2.wr = 1; r2.addr = m_sp - 8'd1; r2.wdata = m_pc;
        r3.done = 1; r3.set_pc = 1; r3.pc_v = d;
        exp_q.push_back(r1); exp_q.push_back(r2); exp_q.push_back(r3);
      end
      3'd5: begin
        r1.rd = 1; r1.addr = m_sp;
        r2.set_sp = 1; r2.sp_v = m_sp + 8'd1;
        r3.done = 1; r3.set_pc = 1; r3.pc_v = m_mem[m_sp];
        exp_q.push_back(r1); exp_q.push_back(r2); exp_q.push_back(r3);
      end
      3'd6: begin
        r1.clr = 1; r1.done = 1;
        exp_q.push_back(r1);
      end
      default: begin
        r1.done = 1; r1.err = 1;
        exp_q.push_back(r1);
      end
    endcase
  endtask

  initial begin
    rec_t r;
    for (int i = 0; i < 256; i++) m_mem[i] = init_byte(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        if (r.set_pcp) m_pcp = r.pcp_v;
        if (r.set_pc)  m_pc  = r.pc_v;
        if (r.set_sp)  m_sp  = r.sp_v;
        if (r.wr)      m_mem[r.addr] = r.wdata;
        if (r.clr) begin m_ar = 8'h00; m_sp = 8'h00; m_pcp = 8'h00; m_pc = 8'h00; end
      end else if (bus.op_valid) begin
        gen(bus.op_code, bus.op_data);
      end
    end
  end

  // Compare process
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk1("rst_ready", bus.op_ready, 1'b1);
        chk8("rst_rsel", {4'd0, arf_rsel}, 8'h00);
        chk8("rst_funsel", {6'd0, arf_funsel}, 8'h01);
        chk8("rst_arf_i", arf_i, 8'h00);
        chk8("rst_mem_addr", bus.mem_addr, 8'h00);
        chk8("rst_mem_wdata", bus.mem_wdata, 8'h00);
        chk1("rst_wr", bus.mem_wr, 1'b0);
        chk1("rst_rd", bus.mem_rd, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
      end else if (exp_q.size() == 0) begin
        chk1("idle_ready", bus.op_ready, 1'b1);
        chk1("idle_done", bus.done, 1'b0);
        chk1("idle_err", bus.err, 1'b0);
        chk1("idle_rd", bus.mem_rd, 1'b0);
        chk1("idle_wr", bus.mem_wr, 1'b0);
        chk8("idle_rsel", {4'd0, arf_rsel}, 8'h00);
        chk8("idle_funsel", {6'd0, arf_funsel}, 8'h01);
        chk8("reg_ar", ar, m_ar);
        chk8("reg_sp", sp, m_sp);
        chk8("reg_pcprev", pcp, m_pcp);
        chk8("reg_pc", pc, m_pc);
      end else begin
        e = exp_q[0];
        chk1("busy_ready", bus.op_ready, 1'b0);
        chk1("step_done", bus.done, e.done);
        chk1("step_err", bus.err, e.err);
        chk1("step_rd", bus.mem_rd, e.rd);
        chk1("step_wr", bus.mem_wr, e.wr);
        if (e.rd || e.wr) chk8("step_addr", bus.mem_addr, e.addr);
        if (e.wr) chk8("step_wdata", bus.mem_wdata, e.wdata);
        if (!(e.set_pc || e.set_sp || e.set_pcp || e.clr)) begin
          chk8("step_rsel", {4'd0, arf_rsel}, 8'h00);
          chk8("step_funsel", {6'd0, arf_funsel}, 8'h01);
        end
      end
    end
  end

  // Presents an op and returns just after the accepting edge (cycle of step 1)
  task automatic do_op(input logic [2:0] c, input logic [7:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = c; bus.op_data = d;
    @(negedge clk);
    while (!bus.op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_ready", bus.op_ready, 1'b1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op_code = 3'($urandom); bus.op_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("reach_idle", bus.op_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] s_ar, s_sp, s_pcp, s_pc;
    bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.op_data = 8'h00;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    do_op(3'd6, 8'h00);
    @(negedge clk);
    chk1("clr_done_c2", bus.done, 1'b1);
    chk1("clr_busy_c2", bus.op_ready, 1'b0);
    @(negedge clk);
    chk1("clr_ready_c3", bus.op_ready, 1'b1);
    chk8("clr_ar", ar, 8'h00);
    chk8("clr_sp", sp, 8'h00);
    chk8("clr_pcp", pcp, 8'h00);
    chk8("clr_pc", pc, 8'h00);

    do_op(3'd1, 8'h3C); wait_idle();
    do_op(3'd0, 8'h00);
    @(negedge clk);
    chk8("fetch_addr", bus.mem_addr, 8'h3C);
    chk1("fetch_rd", bus.mem_rd, 1'b1);
    wait_idle();
    chk8("fetch_pcp", pcp, 8'h3C);
    chk8("fetch_pc", pc, 8'h3D);

    do_op(3'd2, 8'hA5); wait_idle();
    chk8("push_sp", sp, 8'hFF);
    chk8("push_mem", mem[8'hFF], 8'hA5);
    do_op(3'd3, 8'h00);
    @(negedge clk);
    chk8("pop_addr", bus.mem_addr, 8'hFF);
    wait_idle();
    chk8("pop_sp", sp, 8'h00);

    do_op(3'd1, 8'h10); wait_idle();
    repeat (128) begin do_op(3'd3, 8'h00); wait_idle(); end
    chk8("sp_80", sp, 8'h80);
    do_op(3'd4, 8'h40); wait_idle();
    chk8("call_mem", mem[8'h7F], 8'h10);
    chk8("call_sp", sp, 8'h7F);
    chk8("call_pc", pc, 8'h40);
    do_op(3'd5, 8'h00); wait_idle();
    chk8("ret_sp", sp, 8'h80);
    chk8("ret_pc", pc, 8'h10);

    s_ar = ar; s_sp = sp; s_pcp = pcp; s_pc = pc;
    do_op(3'd7, 8'h99);
    @(negedge clk);
    chk1("ill_err", bus.err, 1'b1);
    chk1("ill_done", bus.done, 1'b1);
    wait_idle();
    chk8("ill_ar", ar, s_ar);
    chk8("ill_sp", sp, s_sp);
    chk8("ill_pcp", pcp, s_pcp);
    chk8("ill_pc", pc, s_pc);

    do_op(3'd1, 8'h22); wait_idle();
    do_op(3'd4, 8'h55);
    @(posedge clk); #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk8("abort_pc", pc, 8'h22);
    chk8("abort_sp", sp, 8'h7F);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      bus.op_valid = ($urandom_range(0, 2) != 0);
      bus.op_code  = 3'($urandom);
      bus.op_data  = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1 bus.op_valid = 1'b0;
    repeat (6) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
